async_fifo_rd_ctrl: RTL and testbench

ASYNC_FIFO_RD_CTRL -- requirements
Module: async_fifo_rd_ctrl

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/gray_ptr_sync.sv | 30 +++
 rtl/async_fifo_rd_ctrl.sv | 73 +++++++
 tb/tb_async_fifo_rd_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the asynchronous FIFO read and write controllers.
// The Gray/binary conversions work on a 32-bit word, and callers narrow the result to their pointer width.
package fifo_pkg;

  localparam int DEFAULT_ADDRSIZE = 7;
  localparam int PTR_MAX_W        = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Leading zeros of a zero-extended Gray value leave the XOR prefix unaffected.
  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
// It is shared by the read-side and write-side FIFO controllers.
module gray_ptr_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_ptr,
  output logic [WIDTH-1:0] o_ptr
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_ptr = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO: read pointer, empty/almost-empty flags, fill level and underflow.
// The block holds no storage. raddr drives an external memory.
module async_fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE      = DEFAULT_ADDRSIZE,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                r_en,
  input  logic [ADDRSIZE:0]   wptr_gray,
  output logic [ADDRSIZE:0]   rptr_gray,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AEMPTY_LVL = PW'(AEMPTY_THRESH);

  logic [PW-1:0] r_rbin;
  logic [PW-1:0] w_wq_gray;
  logic [PW-1:0] w_wq_bin;
  logic [PW-1:0] w_rbin_next;
  logic [PW-1:0] w_rgray_next;
  logic [PW-1:0] w_level_next;
  logic          w_rd_ok;
  logic          w_underflow_evt;

  gray_ptr_sync #(
    .WIDTH       (PW),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk   (rclk),
    .rst_n (rrst_n),
    .i_ptr (wptr_gray),
    .o_ptr (w_wq_gray)
  );

  // Next-state pointer arithmetic. Modulo 2**PW subtraction also covers wrap-around, so no address special case is needed.
  assign w_wq_bin        = PW'(gray2bin(ptr_word_t'(w_wq_gray)));
  assign w_rd_ok         = r_en & ~rempty;
  assign w_underflow_evt = r_en & rempty;
  assign w_rbin_next     = r_rbin + PW'(w_rd_ok);
  assign w_rgray_next    = PW'(bin2gray(ptr_word_t'(w_rbin_next)));
  assign w_level_next    = w_wq_bin - w_rbin_next;

  assign raddr = r_rbin[ADDRSIZE-1:0];

  // Registered pointer and status. The flags are computed from the post-read pointer, so they can never show stale data.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rbin     <= '0;
      rptr_gray  <= '0;
      rempty     <= 1'b1;
      raempty    <= 1'b1;
      rlevel     <= '0;
      runderflow <= 1'b0;
    end else begin
      r_rbin     <= w_rbin_next;
      rptr_gray  <= w_rgray_next;
      rempty     <= (w_rgray_next == w_wq_gray);
      raempty    <= (w_level_next <= AEMPTY_LVL);
      rlevel     <= w_level_next;
      runderflow <= runderflow | w_underflow_evt;
    end
  end

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Randomised and directed bench for async_fifo_rd_ctrl (ADDRSIZE=3, SYNC_STAGES=2, AEMPTY_THRESH=4).
// A counter-level model tracks the write count, the read count and the synchroniser delay.
module tb_async_fifo_rd_ctrl;

  localparam int AW = 3;
  localparam int SS = 2;
  localparam int TH = 4;
  localparam int PW = AW + 1;

  logic          rclk      = 1'b0;
  logic          rrst_n    = 1'b0;
  logic          r_en      = 1'b0;
  logic [PW-1:0] wptr_gray = '0;
  logic [PW-1:0] rptr_gray;
  logic [AW-1:0] raddr;
  logic          rempty;
  logic          raempty;
  logic [PW-1:0] rlevel;
  logic          runderflow;

  always #5 rclk = ~rclk;

  async_fifo_rd_ctrl #(
    .ADDRSIZE      (AW),
    .SYNC_STAGES   (SS),
    .AEMPTY_THRESH (TH)
  ) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .r_en       (r_en),
    .wptr_gray  (wptr_gray),
    .rptr_gray  (rptr_gray),
    .raddr      (raddr),
    .rempty     (rempty),
    .raempty    (raempty),
    .rlevel     (rlevel),
    .runderflow (runderflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: entries written (wb) and read (m_rd) as plain counts.
  int m_rd;
  int wb;
  int m_level;
  bit m_empty;
  bit m_aempty;
  bit m_uf;
  int wq_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] gray(input int b);
    int x;
    x = b & ((1 << PW) - 1);
    return PW'(x ^ (x >> 1));
  endfunction

  task automatic model_reset();
    m_rd     = 0;
    wb       = 0;
    m_level  = 0;
    m_empty  = 1'b1;
    m_aempty = 1'b1;
    m_uf     = 1'b0;
    wq_q.delete();
    for (int i = 0; i < SS; i++) wq_q.push_back(0);
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".rempty"},     32'(rempty),     32'(m_empty));
    chk({ctx, ".raempty"},    32'(raempty),    32'(m_aempty));
    chk({ctx, ".rlevel"},     32'(rlevel),     32'(m_level));
    chk({ctx, ".raddr"},      32'(raddr),      32'(m_rd % (1 << AW)));
    chk({ctx, ".rptr_gray"},  32'(rptr_gray),  32'(gray(m_rd)));
    chk({ctx, ".runderflow"}, 32'(runderflow), 32'(m_uf));
  endtask

  // Drive one cycle, then advance the model across the same edge. A write becomes visible SS edges later.
  task automatic cyc(input bit ren, input int wnext, input string ctx);
    int wq;
    r_en      = ren;
    wb        = wnext;
    wptr_gray = gray(wb);
    @(posedge rclk);
    wq = wq_q.pop_front();
    wq_q.push_back(wb);
    if (ren && m_empty) m_uf = 1'b1;
    if (ren && !m_empty) m_rd++;
    m_level  = (wq - m_rd) & ((1 << PW) - 1);
    m_empty  = (m_level == 0);
    m_aempty = (m_level <= TH);
    #1;
    check_all(ctx);
  endtask

  task automatic do_reset(input bit chk_async);
    rrst_n    = 1'b0;
    r_en      = 1'b0;
    wptr_gray = '0;
    model_reset();
    if (chk_async) begin
      #1;
      check_all("rst_async");
    end
    @(posedge rclk);
    #1;
    check_all("rst_hold");
    rrst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int guard;
    bit ren;

    do_reset(1'b0);
    repeat (2) cyc(1'b0, 0, "idle");
    chk("init_raddr",  32'(raddr),   32'd0);
    chk("init_rempty", 32'(rempty),  32'd1);
    chk("init_rlevel", 32'(rlevel),  32'd0);

    // One write: rempty falls on the third edge.
    cyc(1'b0, 1, "w1e1");
    chk("w1_e1_rempty", 32'(rempty), 32'd1);
    cyc(1'b0, 1, "w1e2");
    chk("w1_e2_rempty", 32'(rempty), 32'd1);
    cyc(1'b0, 1, "w1e3");
    chk("w1_e3_rempty", 32'(rempty), 32'd0);
    chk("w1_e3_rlevel", 32'(rlevel), 32'd1);

    // Fill to 8, then read the whole FIFO back to back.
    for (int i = 2; i <= 8; i++) cyc(1'b0, i, "fill");
    repeat (3) cyc(1'b0, 8, "fill_settle");
    chk("fill8_level", 32'(rlevel), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rd%0d_raddr", i), 32'(raddr), 32'(i));
      cyc(1'b1, 8, "rd8");
      chk($sformatf("rd%0d_aempty", i), 32'(raempty), 32'((7 - i) <= TH));
    end
    chk("rd8_rempty", 32'(rempty),     32'd1);
    chk("rd8_rptr",   32'(rptr_gray),  32'h0000000c);
    chk("rd8_uf",     32'(runderflow), 32'd0);

    // Reads while empty: the pointer is frozen and the underflow flag is sticky.
    cyc(1'b1, 8, "uf");
    chk("uf_set",  32'(runderflow), 32'd1);
    chk("uf_rptr", 32'(rptr_gray),  32'h0000000c);
    repeat (3) cyc(1'b1, 8, "uf_hold");
    repeat (3) cyc(1'b0, 8, "uf_idle");
    chk("uf_sticky", 32'(runderflow), 32'd1);
    do_reset(1'b1);
    chk("uf_cleared", 32'(runderflow), 32'd0);

    // Level 6 drained to 0: raempty rises at level 4.
    for (int i = 1; i <= 6; i++) cyc(1'b0, i, "fill6");
    repeat (3) cyc(1'b0, 6, "fill6_settle");
    chk("ae6_level",  32'(rlevel),  32'd6);
    chk("ae6_aempty", 32'(raempty), 32'd0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 6, "drain6");
      chk($sformatf("drain_lvl%0d", 5 - i), 32'(rlevel),  32'(5 - i));
      chk($sformatf("drain_ae%0d", 5 - i),  32'(raempty), 32'((5 - i) <= TH));
    end

    // Move the read pointer to 15 while the write count reaches 17, then read across the wrap.
    guard = 0;
    while (m_rd < 15 && guard < 200) begin
      w   = (wb < 17) ? wb + 1 : 17;
      ren = !m_empty && (m_rd < 15);
      cyc(ren, w, "wrap_setup");
      guard++;
    end
    repeat (4) cyc(1'b0, 17, "wrap_settle");
    chk("wrap_pre_rptr",  32'(rptr_gray), 32'h00000008);
    chk("wrap_pre_raddr", 32'(raddr),     32'd7);
    chk("wrap_pre_level", 32'(rlevel),    32'd2);
    cyc(1'b1, 17, "wrap_rd");
    chk("wrap_post_level", 32'(rlevel),     32'd1);
    chk("wrap_post_rptr",  32'(rptr_gray),  32'd0);
    chk("wrap_post_raddr", 32'(raddr),      32'd0);
    chk("wrap_post_uf",    32'(runderflow), 32'd0);
    repeat (3) cyc(1'b0, 18, "wrap_w18");
    chk("wrap_w18_level", 32'(rlevel), 32'd2);

    // Random traffic with varying read pressure and occasional resets during operation.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset(1'b1);
      end else begin
        case ((i / 500) % 3)
          0:       ren = ($urandom_range(0, 3) == 0);
          1:       ren = ($urandom_range(0, 3) != 0);
          default: ren = $urandom_range(0, 1) != 0;
        endcase
        w = wb;
        if ($urandom_range(0, 1) != 0 && (wb + 1 - m_rd) <= (1 << AW)) w = wb + 1;
        cyc(ren, w, "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
